// File: rtl/axis_s_to_ad9764_pkg.sv
// rtl/axis_s_to_ad9764_pkg.sv - shared state encodings and constants for the AD9764 stream player
package axis_s_to_ad9764_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SECOND = 2'd2,
        ST_PAUSE  = 2'd3
    } state_t;

    // Offset-binary code for a zero sample; driven whenever no sample is playing.
    localparam logic [13:0] DAC_MIDSCALE = 14'h2000;

    // Bit positions inside the 4-bit software control word.
    localparam int CTRL_DAC_EN = 0;
    localparam int CTRL_PA_EN  = 1;
    localparam int CTRL_PAUSE  = 3;

endpackage

// File: rtl/ad9764_sample_fmt.sv
// rtl/ad9764_sample_fmt.sv - two's-complement 14-bit sample to AD9764 offset-binary code
module ad9764_sample_fmt (
    input  logic [13:0] i_sample,
    output logic [13:0] o_code
);

    // Adding half scale to a two's-complement value is just an MSB flip.
    assign o_code = {~i_sample[13], i_sample[12:0]};

endmodule

// File: rtl/axis_s_to_ad9764.sv
// rtl/axis_s_to_ad9764.sv - AXI4-Stream slave playing two packed samples per word into an AD9764 DAC
module axis_s_to_ad9764
    import axis_s_to_ad9764_pkg::*;
(
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_aresetn,
    input  logic [31:0] s00_axis_tdata,
    input  logic        s00_axis_tvalid,
    output logic        s00_axis_tready,
    input  logic [3:0]  s00_axis_tstrb,
    input  logic        s00_axis_tlast,
    input  logic [3:0]  control,
    output logic [13:0] DAC_data,
    output logic        ClockToDAC,
    output logic        DAC_sleep,
    output logic        PA_enable,
    output logic [1:0]  state
);

    // The reset input is active-high despite its name.
    logic        w_rst;
    logic        w_en;
    logic        w_pause;
    logic        w_accept;

    state_t      r_state;
    state_t      w_next_state;

    logic [13:0] r_second_slot;
    logic [13:0] r_dac_data;
    logic        r_dac_sleep;
    logic        r_pa_enable;
    logic        r_dac_en;

    logic [13:0] w_first_code;
    logic [13:0] w_second_code;
    logic [13:0] w_dac_next;
    logic        w_load_second;

    // Stream sideband, reserved control bit and slot padding bits carry no meaning here.
    logic        w_unused;

    assign w_rst    = s00_axis_aresetn;
    assign w_en     = control[CTRL_DAC_EN];
    assign w_pause  = control[CTRL_PAUSE];
    assign w_accept = (r_state == ST_WAIT) && s00_axis_tvalid;
    assign w_unused = ^{s00_axis_tstrb, s00_axis_tlast, control[2],
                        s00_axis_tdata[31:30], s00_axis_tdata[15:14]};

    ad9764_sample_fmt u_fmt_first (
        .i_sample (s00_axis_tdata[13:0]),
        .o_code   (w_first_code)
    );

    ad9764_sample_fmt u_fmt_second (
        .i_sample (r_second_slot),
        .o_code   (w_second_code)
    );

    // State register.
    always_ff @(posedge s00_axis_aclk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; disable overrides everything, pause never splits a word.
    always_comb begin
        w_next_state = r_state;
        if (!w_en) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_next_state = w_pause ? ST_PAUSE : ST_WAIT;
                ST_WAIT: begin
                    if (s00_axis_tvalid) begin
                        w_next_state = ST_SECOND;
                    end else if (w_pause) begin
                        w_next_state = ST_PAUSE;
                    end
                end
                ST_SECOND: w_next_state = w_pause ? ST_PAUSE : ST_WAIT;
                ST_PAUSE: begin
                    if (!w_pause) begin
                        w_next_state = ST_WAIT;
                    end
                end
                default:   w_next_state = ST_IDLE;
            endcase
        end
    end

    // Output decode: choose the DAC code for the coming cycle; midscale on underrun, pause or idle.
    always_comb begin
        w_dac_next    = DAC_MIDSCALE;
        w_load_second = 1'b0;
        if (w_en) begin
            if (w_accept) begin
                w_dac_next    = w_first_code;
                w_load_second = 1'b1;
            end else if (r_state == ST_SECOND) begin
                w_dac_next    = w_second_code;
            end
        end
    end

    // Output and second-slot registers.
    always_ff @(posedge s00_axis_aclk or posedge w_rst) begin
        if (w_rst) begin
            r_second_slot <= 14'd0;
            r_dac_data    <= DAC_MIDSCALE;
            r_dac_sleep   <= 1'b1;
            r_pa_enable   <= 1'b0;
            r_dac_en      <= 1'b0;
        end else begin
            if (w_load_second) begin
                r_second_slot <= s00_axis_tdata[29:16];
            end
            r_dac_data  <= w_dac_next;
            r_dac_sleep <= (w_next_state == ST_IDLE);
            r_pa_enable <= control[CTRL_PA_EN] & w_en;
            r_dac_en    <= w_en;
        end
    end

    // Forwarded clock is inverted so the DAC latches mid-cycle; the enable only
    // changes just after a rising edge, while the inverted clock is already low.
    assign ClockToDAC      = r_dac_en & ~s00_axis_aclk;

    assign s00_axis_tready = (r_state == ST_WAIT);
    assign DAC_data        = r_dac_data;
    assign DAC_sleep       = r_dac_sleep;
    assign PA_enable       = r_pa_enable;
    assign state           = r_state;

endmodule

// File: tb/tb_axis_s_to_ad9764.sv
// tb/tb_axis_s_to_ad9764.sv - scoreboard bench for the AD9764 stream player
module tb_axis_s_to_ad9764;

    logic        clk;
    logic        rst;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [3:0]  tstrb;
    logic        tlast;
    logic [3:0]  control;
    logic [13:0] dac_data;
    logic        clk_to_dac;
    logic        dac_sleep;
    logic        pa_enable;
    logic [1:0]  dbg_state;

    axis_s_to_ad9764 dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst),
        .s00_axis_tdata   (tdata),
        .s00_axis_tvalid  (tvalid),
        .s00_axis_tready  (tready),
        .s00_axis_tstrb   (tstrb),
        .s00_axis_tlast   (tlast),
        .control          (control),
        .DAC_data         (dac_data),
        .ClockToDAC       (clk_to_dac),
        .DAC_sleep        (dac_sleep),
        .PA_enable        (pa_enable),
        .state            (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st;
        int dac;
        int rdy;
        int slp;
        int pa;
        int clk_en;
    } exp_t;

    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: player is off, waiting, or paused; accepted words become
    // a queue of pending sample codes that drains one per clock.
    localparam int M_OFF    = 0;
    localparam int M_WAIT   = 1;
    localparam int M_PAUSED = 2;
    localparam int MID      = 8192;

    int m_mode = M_OFF;
    int m_pend[$];
    int m_dac  = MID;
    int m_pa   = 0;
    int m_en   = 0;

    function automatic int to_code(input logic [15:0] slot);
        int s;
        s = int'(slot[13:0]);
        if (s >= 8192) s = s - 16384;
        return s + 8192;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] c, input logic v, input logic [31:0] d,
                              input logic r, output logic acc);
        exp_t e;
        acc = 1'b0;
        if (r) begin
            m_pend.delete();
            m_mode = M_OFF;
            m_dac  = MID;
            m_pa   = 0;
            m_en   = 0;
        end else begin
            m_pa = int'(c[1] & c[0]);
            m_en = int'(c[0]);
            if (!c[0]) begin
                m_pend.delete();
                m_mode = M_OFF;
                m_dac  = MID;
            end else if (m_pend.size() != 0) begin
                m_dac  = m_pend.pop_front();
                m_mode = c[3] ? M_PAUSED : M_WAIT;
            end else if (m_mode == M_OFF) begin
                m_mode = c[3] ? M_PAUSED : M_WAIT;
                m_dac  = MID;
            end else if (m_mode == M_WAIT) begin
                if (v) begin
                    acc   = 1'b1;
                    m_dac = to_code(d[15:0]);
                    m_pend.push_back(to_code(d[31:16]));
                end else begin
                    m_dac = MID;
                    if (c[3]) m_mode = M_PAUSED;
                end
            end else begin
                m_dac = MID;
                if (!c[3]) m_mode = M_WAIT;
            end
        end
        if (m_pend.size() != 0)      e.st = 2;
        else if (m_mode == M_OFF)    e.st = 0;
        else if (m_mode == M_WAIT)   e.st = 1;
        else                         e.st = 3;
        e.dac    = m_dac;
        e.rdy    = (m_mode == M_WAIT && m_pend.size() == 0) ? 1 : 0;
        e.slp    = (m_mode == M_OFF) ? 1 : 0;
        e.pa     = m_pa;
        e.clk_en = m_en;
        sb_q.push_back(e);
    endtask

    logic last_acc;

    task automatic cycle(input logic [3:0] c, input logic v, input logic [31:0] d, input logic r);
        logic a;
        @(negedge clk);
        rst     = r;
        control = c;
        tvalid  = v;
        tdata   = d;
        tstrb   = 4'($urandom);
        tlast   = 1'($urandom);
        model_step(c, v, d, r, a);
        last_acc = a;
    endtask

    // Reset asserted in the high phase of a cycle: outputs must fall back at once.
    task automatic async_reset();
        logic a;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_state", int'(dbg_state), 0);
        chk("async_dac", int'(dac_data), MID);
        chk("async_sleep", int'(dac_sleep), 1);
        chk("async_pa", int'(pa_enable), 0);
        chk("async_tready", int'(tready), 0);
        model_step(4'b0000, 1'b0, 32'd0, 1'b1, a);
        void'(sb_q.pop_back());
    endtask

    // Monitor: pops one expectation per clock and compares after the edge settles.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("state", int'(dbg_state), e.st);
                chk("dac_data", int'(dac_data), e.dac);
                chk("tready", int'(tready), e.rdy);
                chk("dac_sleep", int'(dac_sleep), e.slp);
                chk("pa_enable", int'(pa_enable), e.pa);
                chk("clk_to_dac_hi", int'(clk_to_dac), 0);
                @(negedge clk);
                #1;
                chk("clk_to_dac_lo", int'(clk_to_dac), (e.clk_en != 0 && !rst) ? 1 : 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] cnt;
        logic [3:0]  c;
        rst      = 1'b1;
        control  = 4'b0000;
        tvalid   = 1'b0;
        tdata    = 32'd0;
        tstrb    = 4'd0;
        tlast    = 1'b0;
        last_acc = 1'b0;

        repeat (3) cycle(4'b0000, 1'b0, 32'd0, 1'b1);
        repeat (2) cycle(4'b0000, 1'b0, 32'd0, 1'b0);

        cycle(4'b0011, 1'b0, 32'd0, 1'b0);
        cycle(4'b0011, 1'b1, 32'h0002_0001, 1'b0);
        cycle(4'b0011, 1'b0, 32'd0, 1'b0);
        cycle(4'b0011, 1'b0, 32'd0, 1'b0);
        cycle(4'b0011, 1'b1, 32'h3FFF_2000, 1'b0);
        cycle(4'b0011, 1'b0, 32'd0, 1'b0);

        // Counting stream with tvalid held; data only advances after an accept.
        cnt = 14'd0;
        repeat (20) begin
            cycle(4'b0011, 1'b1, {2'b00, cnt + 14'd1, 2'b11, cnt}, 1'b0);
            if (last_acc) cnt = cnt + 14'd2;
        end

        // Pause while streaming: once from a WAIT edge, once from a SECOND edge.
        repeat (4) begin
            cycle(4'b1011, 1'b1, {2'b00, cnt + 14'd1, 2'b00, cnt}, 1'b0);
            if (last_acc) cnt = cnt + 14'd2;
        end
        repeat (3) begin
            cycle(4'b0011, 1'b1, {2'b00, cnt + 14'd1, 2'b00, cnt}, 1'b0);
            if (last_acc) cnt = cnt + 14'd2;
        end
        repeat (3) begin
            cycle(4'b1011, 1'b1, {2'b00, cnt + 14'd1, 2'b00, cnt}, 1'b0);
            if (last_acc) cnt = cnt + 14'd2;
        end
        cycle(4'b0011, 1'b0, 32'd0, 1'b0);
        cycle(4'b0011, 1'b0, 32'd0, 1'b0);

        // Disable while the second slot is pending.
        cycle(4'b0011, 1'b1, 32'h1234_0FFF, 1'b0);
        cycle(4'b0010, 1'b1, 32'h1234_0FFF, 1'b0);
        cycle(4'b0010, 1'b0, 32'd0, 1'b0);
        cycle(4'b1001, 1'b0, 32'd0, 1'b0);
        cycle(4'b0001, 1'b0, 32'd0, 1'b0);

        // Reset in the middle of a word.
        cycle(4'b0011, 1'b1, 32'h2AAA_1555, 1'b0);
        async_reset();
        cycle(4'b0011, 1'b1, 32'h2AAA_1555, 1'b1);
        cycle(4'b0011, 1'b0, 32'd0, 1'b0);

        // Randomized traffic, mostly enabled, occasional pause and disable.
        for (int i = 0; i < 400; i++) begin
            c = 4'($urandom);
            c[0] = ($urandom_range(0, 15) != 0);
            c[3] = ($urandom_range(0, 5) == 0);
            cycle(c, 1'($urandom), $urandom, 1'b0);
            if (i == 200) begin
                async_reset();
                cycle(4'b0000, 1'b0, 32'd0, 1'b1);
            end
        end

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
